// File: rtl/fp_divider_if.sv
// fp_divider_if: request/response bundle for the single-precision divider
//   start     - request, honoured only while the divider is idle
//   A, B      - dividend / divisor, captured on an accepted start
//   busy      - operation in flight
//   done      - one-cycle pulse, result and flags valid
//   result    - quotient A/B
//   overflow  - result exponent above 254
//   underflow - result exponent below 1
//   exception - divide-by-zero or Inf/NaN operand
interface fp_divider_if #(parameter int XLEN = 32);
   logic            start;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            overflow;
   logic            underflow;
   logic            exception;
   modport master (output start, A, B, input busy, done, result, overflow, underflow, exception);
   modport slave  (input start, A, B, output busy, done, result, overflow, underflow, exception);
endinterface

// File: rtl/fp_divider.sv
// fp_divider: multi-cycle IEEE-754 single-precision divider, restoring, truncating
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - fp_divider_if slave (start/A/B in, busy/done/result/flags out)
module fp_divider #(parameter int XLEN = 32) (
   input logic        clk,
   input logic        rst,
   fp_divider_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE} state_t;
   state_t            r_state, w_next;
   logic [4:0]        r_cnt;
   logic              r_sign;
   logic [7:0]        r_ea, r_eb;
   logic [23:0]       r_mb;
   logic [24:0]       r_rem, r_q;
   logic [XLEN-1:0]   r_result;
   logic              r_done, r_ovf, r_unf, r_exc;
   logic              w_ge;
   logic [23:0]       w_diff;
   logic signed [9:0] w_exp;
   logic [22:0]       w_man;
   logic [XLEN-1:0]   w_res;
   logic              w_ovf, w_unf, w_exc;
   assign bus.busy      = r_state != IDLE;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.overflow  = r_ovf;
   assign bus.underflow = r_unf;
   assign bus.exception = r_exc;
   // remainder stays below 2*Mb, so after a subtraction it fits in 24 bits
   assign w_ge   = r_rem >= {1'b0, r_mb};
   assign w_diff = w_ge ? 24'(r_rem - {1'b0, r_mb}) : r_rem[23:0];
   // q[24] set means the quotient is in [1,2); otherwise q[23] is the leading one
   assign w_exp = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + (r_q[24] ? 10'sd127 : 10'sd126);
   assign w_man = r_q[24] ? r_q[23:1] : r_q[22:0];
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? DIVIDE : IDLE;
         DIVIDE:  w_next = (r_cnt == 5'd24) ? NORMALIZE : DIVIDE;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      w_res = {r_sign, w_exp[7:0], w_man};
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_exc = 1'b0;
      if (r_ea == 8'hFF || r_eb == 8'hFF) begin
         w_res = {r_sign, 8'hFF, 23'h400000};
         w_exc = 1'b1;
      end else if (r_eb == 8'h00) begin
         w_res = {r_sign, 8'hFF, 23'd0};
         w_exc = 1'b1;
      end else if (r_ea == 8'h00) begin
         w_res = {r_sign, 31'd0};
      end else if (w_exp > 10'sd254) begin
         w_res = {r_sign, 8'hFF, 23'd0};
         w_ovf = 1'b1;
      end else if (w_exp < 10'sd1) begin
         w_res = {r_sign, 31'd0};
         w_unf = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= 5'd0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_exc    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_sign <= bus.A[31] ^ bus.B[31];
               r_ea   <= bus.A[30:23];
               r_eb   <= bus.B[30:23];
               r_mb   <= {1'b1, bus.B[22:0]};
               r_rem  <= {2'b01, bus.A[22:0]};
               r_q    <= '0;
               r_cnt  <= 5'd0;
            end
            DIVIDE: begin
               r_q   <= {r_q[23:0], w_ge};
               r_rem <= {w_diff, 1'b0};
               r_cnt <= r_cnt + 5'd1;
            end
            default: begin
               r_result <= w_res;
               r_ovf    <= w_ovf;
               r_unf    <= w_unf;
               r_exc    <= w_exc;
               r_done   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed self-checking bench for fp_divider
module tb_fp_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   fp_divider_if #(.XLEN(32)) bus ();
   fp_divider #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // done is seen in the cycle after the 26th edge following the start edge (cycle k+27)
   localparam int LAT = 26;
   localparam int NV  = 25;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [2:0]  f;
   } vec_t;
   // flags are {overflow, underflow, exception}
   vec_t tv [NV] = '{
      '{32'h40C00000, 32'h40000000, 32'h40400000, 3'b000},
      '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000},
      '{32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000},
      '{32'hC0C00000, 32'hC0000000, 32'h40400000, 3'b000},
      '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000},
      '{32'h40000000, 32'h3F800000, 32'h40000000, 3'b000},
      '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 3'b000},
      '{32'h40400000, 32'h3FA00000, 32'h40199999, 3'b000},
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001},
      '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 3'b001},
      '{32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001},
      '{32'h00000000, 32'h40000000, 32'h00000000, 3'b000},
      '{32'h80000000, 32'h40000000, 32'h80000000, 3'b000},
      '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000},
      '{32'h3F800000, 32'h7F800000, 32'h7FC00000, 3'b001},
      '{32'h00000000, 32'h00000000, 32'h7F800000, 3'b001},
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001},
      '{32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100},
      '{32'h00800000, 32'h7F000000, 32'h00000000, 3'b010},
      '{32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000},
      '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000},
      '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 3'b100},
      '{32'h00800000, 32'h3F800001, 32'h00000000, 3'b010},
      '{32'h80800000, 32'h7F000000, 32'h80000000, 3'b010},
      '{32'hFF000000, 32'h00800000, 32'hFF800000, 3'b100}
   };
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [2:0] fl, output int lat);
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) lat = n;
      end
      res = bus.result;
      fl  = {bus.overflow, bus.underflow, bus.exception};
   endtask
   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.A     = 32'h40C00000;
      bus.B     = 32'h40000000;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
      n_vec++;
      if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", bus.done); end
      n_vec++;
      if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset result: got %h expected 00000000", bus.result); end
      n_vec++;
      if ({bus.overflow, bus.underflow, bus.exception} !== 3'b000) begin
         n_err++;
         $display("FAIL reset flags: got %b expected 000", {bus.overflow, bus.underflow, bus.exception});
      end
      bus.start = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle busy: got %b expected 0", bus.busy); end
   endtask
   task automatic test_normal();
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         run_op(tv[i].a, tv[i].b, res, fl, lat);
         n_vec++;
         if (res !== tv[i].r) begin n_err++; $display("FAIL normal[%0d] result: got %h expected %h", i, res, tv[i].r); end
         n_vec++;
         if (fl !== tv[i].f) begin n_err++; $display("FAIL normal[%0d] flags: got %b expected %b", i, fl, tv[i].f); end
         n_vec++;
         if (lat !== LAT) begin n_err++; $display("FAIL normal[%0d] latency: got %0d expected %0d", i, lat, LAT); end
      end
   endtask
   task automatic test_specials();
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      for (int i = 8; i < 17; i++) begin
         run_op(tv[i].a, tv[i].b, res, fl, lat);
         n_vec++;
         if (res !== tv[i].r) begin n_err++; $display("FAIL special[%0d] result: got %h expected %h", i, res, tv[i].r); end
         n_vec++;
         if (fl !== tv[i].f) begin n_err++; $display("FAIL special[%0d] flags: got %b expected %b", i, fl, tv[i].f); end
         n_vec++;
         if (lat !== LAT) begin n_err++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, LAT); end
      end
   endtask
   task automatic test_bounds();
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      for (int i = 17; i < NV; i++) begin
         run_op(tv[i].a, tv[i].b, res, fl, lat);
         n_vec++;
         if (res !== tv[i].r) begin n_err++; $display("FAIL bound[%0d] result: got %h expected %h", i, res, tv[i].r); end
         n_vec++;
         if (fl !== tv[i].f) begin n_err++; $display("FAIL bound[%0d] flags: got %b expected %b", i, fl, tv[i].f); end
         n_vec++;
         if (lat !== LAT) begin n_err++; $display("FAIL bound[%0d] latency: got %0d expected %0d", i, lat, LAT); end
      end
   endtask
   task automatic test_timing();
      int nb = 0;
      int nd = 0;
      int dn = -1;
      bus.A     = 32'h40C00000;
      bus.B     = 32'h40000000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int n = 0; n <= 32; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         if (bus.busy) nb++;
         if (bus.done) begin
            nd++;
            if (dn < 0) dn = n;
         end
      end
      n_vec++;
      if (nb !== 26) begin n_err++; $display("FAIL timing busy cycles: got %0d expected 26", nb); end
      n_vec++;
      if (nd !== 1) begin n_err++; $display("FAIL timing done cycles: got %0d expected 1", nd); end
      n_vec++;
      if (dn !== LAT) begin n_err++; $display("FAIL timing done position: got %0d expected %0d", dn, LAT); end
   endtask
   task automatic test_busy_ignore();
      int lat = -1;
      int nd  = 0;
      bus.A     = 32'h40C00000;
      bus.B     = 32'h40000000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(posedge clk);
         #1;
         if (n == 3) begin
            bus.start = 1'b1;
            bus.A     = 32'h3F800000;
            bus.B     = 32'h00000000;
         end
         if (n == 20) bus.start = 1'b0;
         if (bus.done) lat = n;
      end
      n_vec++;
      if (lat !== LAT) begin n_err++; $display("FAIL ignore latency: got %0d expected %0d", lat, LAT); end
      n_vec++;
      if (bus.result !== 32'h40400000) begin n_err++; $display("FAIL ignore result: got %h expected 40400000", bus.result); end
      n_vec++;
      if (bus.exception !== 1'b0) begin n_err++; $display("FAIL ignore exception: got %b expected 0", bus.exception); end
      for (int n = 0; n < 35; n++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) nd++;
      end
      n_vec++;
      if (nd !== 0) begin n_err++; $display("FAIL ignore queued op: got %0d active cycles expected 0", nd); end
      n_vec++;
      if (bus.result !== 32'h40400000) begin n_err++; $display("FAIL ignore hold: got %h expected 40400000", bus.result); end
   endtask
   task automatic test_back_to_back();
      int          d1 = -1;
      int          d2 = -1;
      int          nd = 0;
      logic [31:0] r1 = '0;
      logic [31:0] r2 = '0;
      bus.A     = 32'h40C00000;
      bus.B     = 32'h40000000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.A = 32'h3F800000;
      bus.B = 32'h40400000;
      for (int n = 1; n <= 70; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            nd++;
            if (d1 < 0) begin
               d1 = n;
               r1 = bus.result;
            end else if (d2 < 0) begin
               d2 = n;
               r2 = bus.result;
               bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      n_vec++;
      if (d1 !== LAT) begin n_err++; $display("FAIL b2b first done: got %0d expected %0d", d1, LAT); end
      n_vec++;
      if (d2 - d1 !== 27) begin n_err++; $display("FAIL b2b spacing: got %0d expected 27", d2 - d1); end
      n_vec++;
      if (r1 !== 32'h40400000) begin n_err++; $display("FAIL b2b first result: got %h expected 40400000", r1); end
      n_vec++;
      if (r2 !== 32'h3EAAAAAA) begin n_err++; $display("FAIL b2b second result: got %h expected 3EAAAAAA", r2); end
      n_vec++;
      if (nd !== 2) begin n_err++; $display("FAIL b2b done count: got %0d expected 2", nd); end
   endtask
   task automatic test_mid_reset();
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      int          nd = 0;
      bus.A     = 32'h40C00000;
      bus.B     = 32'h40000000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort busy: got %b expected 0", bus.busy); end
      n_vec++;
      if (bus.result !== 32'h0) begin n_err++; $display("FAIL abort result: got %h expected 00000000", bus.result); end
      n_vec++;
      if ({bus.done, bus.overflow, bus.underflow, bus.exception} !== 4'b0000) begin
         n_err++;
         $display("FAIL abort done/flags: got %b expected 0000", {bus.done, bus.overflow, bus.underflow, bus.exception});
      end
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) nd++;
      end
      n_vec++;
      if (nd !== 0) begin n_err++; $display("FAIL abort done pulse: got %0d expected 0", nd); end
      run_op(32'h3F800000, 32'h40400000, res, fl, lat);
      n_vec++;
      if (res !== 32'h3EAAAAAA) begin n_err++; $display("FAIL after abort result: got %h expected 3EAAAAAA", res); end
      n_vec++;
      if (lat !== LAT) begin n_err++; $display("FAIL after abort latency: got %0d expected %0d", lat, LAT); end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      test_reset();
      test_normal();
      test_specials();
      test_bounds();
      test_timing();
      test_busy_ignore();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
